// File: rtl/dlx_mem_arbiter_if.sv
// rtl/dlx_mem_arbiter_if.sv - fetch, data and memory bus bundle for dlx_mem_arbiter
interface dlx_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_data_read;
  logic              i_data_valid;

  logic              d_req;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_data_write;
  logic              d_write_enable;
  logic [DATA_W-1:0] d_data_read;
  logic              d_data_valid;

  logic              m_req;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_data_write;
  logic              m_write_enable;
  logic [DATA_W-1:0] m_data_read;
  logic              m_data_valid;

  // Arbiter side
  modport slave (
    input  i_req, i_address,
    input  d_req, d_address, d_data_write, d_write_enable,
    input  m_data_read, m_data_valid,
    output i_data_read, i_data_valid,
    output d_data_read, d_data_valid,
    output m_req, m_address, m_data_write, m_write_enable
  );

  // Core requesters plus memory
  modport master (
    output i_req, i_address,
    output d_req, d_address, d_data_write, d_write_enable,
    output m_data_read, m_data_valid,
    input  i_data_read, i_data_valid,
    input  d_data_read, d_data_valid,
    input  m_req, m_address, m_data_write, m_write_enable
  );
endinterface

// File: rtl/dlx_mem_arbiter.sv
// rtl/dlx_mem_arbiter.sv - round-robin arbiter sharing one memory between DLX fetch and data ports
// Optional grant watchdog enabled by defining DLX_MEM_ARB_TIMEOUT_EN.
module dlx_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  dlx_mem_arbiter_if.slave bus,
  output logic             arb_busy,
  output logic             arb_err
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT_I, S_GRANT_D, S_RESP} state_t;

  localparam logic [DATA_W-1:0] C_TMO_DATA = DATA_W'(32'hDEADBEEF);

  state_t            r_state;
  state_t            w_next;
  logic              r_last_d;
  logic              r_m_req;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_valid;
  logic              r_d_valid;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_done;
  logic              w_tmo;
  logic              w_expired;

`ifdef DLX_MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_tmo;
      if (w_grant_i || w_grant_d)
        r_cnt <= '0;
      else if (r_state == S_GRANT_I || r_state == S_GRANT_D)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_expired = (r_cnt == CNT_W'(TIMEOUT));
  assign arb_err   = r_err;
`else
  assign w_expired = 1'b0;
  assign arb_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // On a tie the port not served last wins; completion beats the watchdog.
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_done    = 1'b0;
    w_tmo     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_req && (!bus.d_req || r_last_d)) begin
          w_grant_i = 1'b1;
          w_next    = S_GRANT_I;
        end else if (bus.d_req) begin
          w_grant_d = 1'b1;
          w_next    = S_GRANT_D;
        end
      end
      S_GRANT_I, S_GRANT_D: begin
        if (bus.m_data_valid) begin
          w_done = 1'b1;
          w_next = S_RESP;
        end else if (w_expired) begin
          w_tmo  = 1'b1;
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_d  <= 1'b0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
    end else begin
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      if (w_grant_i) begin
        r_last_d  <= 1'b0;
        r_m_req   <= 1'b1;
        r_m_addr  <= bus.i_address;
        r_m_wdata <= '0;
        r_m_we    <= 1'b0;
      end else if (w_grant_d) begin
        r_last_d  <= 1'b1;
        r_m_req   <= 1'b1;
        r_m_addr  <= bus.d_address;
        r_m_wdata <= bus.d_data_write;
        r_m_we    <= bus.d_write_enable;
      end
      if (w_done || w_tmo) begin
        r_m_req <= 1'b0;
        r_m_we  <= 1'b0;
        if (r_state == S_GRANT_I) begin
          r_i_valid <= 1'b1;
          r_i_rdata <= w_tmo ? C_TMO_DATA : bus.m_data_read;
        end else begin
          r_d_valid <= 1'b1;
          r_d_rdata <= w_tmo ? C_TMO_DATA : (r_m_we ? '0 : bus.m_data_read);
        end
      end
    end
  end

  assign bus.m_req          = r_m_req;
  assign bus.m_address      = r_m_addr;
  assign bus.m_data_write   = r_m_wdata;
  assign bus.m_write_enable = r_m_we;
  assign bus.i_data_read    = r_i_rdata;
  assign bus.i_data_valid   = r_i_valid;
  assign bus.d_data_read    = r_d_rdata;
  assign bus.d_data_valid   = r_d_valid;
  assign arb_busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// tb/tb_dlx_mem_arbiter.sv - scoreboard bench for dlx_mem_arbiter with a transaction-level reference model
module tb_dlx_mem_arbiter;

  localparam int TMO = 8;
`ifdef DLX_MEM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } txn_t;

  typedef enum {M_IDLE, M_GRANT, M_RESP} mst_t;

  logic clk = 1'b0;
  logic reset_n;
  logic arb_busy;
  logic arb_err;
  int   checks = 0;
  int   errors = 0;
  bit   mem_auto = 1'b0;

  dlx_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dlx_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .arb_busy (arb_busy),
    .arb_err  (arb_err)
  );

  always #5 clk = ~clk;

  txn_t qi[$];
  txn_t qd[$];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the memory this cycle, derived from the requests of the previous cycle
  mst_t        ms = M_IDLE;
  bit          own_d, last_d, m_tmo, new_grant;
  bit          p_i, p_d, p_mv;
  int          gcyc;
  txn_t        cur;
  logic [31:0] exp_ird, exp_drd, rexp;

  always @(negedge clk) begin
    if (!reset_n) begin
      ms = M_IDLE; last_d = 1'b0; p_i = 1'b0; p_d = 1'b0; p_mv = 1'b0;
      exp_ird = '0; exp_drd = '0;
      chk("rst_m_req", bus.m_req, 0);
      chk("rst_m_address", bus.m_address, 0);
      chk("rst_m_data_write", bus.m_data_write, 0);
      chk("rst_m_we", bus.m_write_enable, 0);
      chk("rst_i_data_read", bus.i_data_read, 0);
      chk("rst_d_data_read", bus.d_data_read, 0);
      chk("rst_i_valid", bus.i_data_valid, 0);
      chk("rst_d_valid", bus.d_data_valid, 0);
      chk("rst_busy", arb_busy, 0);
      chk("rst_err", arb_err, 0);
    end else begin
      new_grant = 1'b0;
      case (ms)
        M_IDLE: if (p_i || p_d) begin
          own_d = p_d && (!p_i || !last_d);
          last_d = own_d;
          ms = M_GRANT; gcyc = 1; new_grant = 1'b1;
        end
        M_GRANT: begin
          if (p_mv) begin ms = M_RESP; m_tmo = 1'b0; end
          else if (TMO_EN && gcyc == TMO + 1) begin ms = M_RESP; m_tmo = 1'b1; end
          else gcyc++;
        end
        M_RESP: ms = M_IDLE;
        default: ms = M_IDLE;
      endcase

      chk("m_req", bus.m_req, ms == M_GRANT);
      chk("arb_busy", arb_busy, ms != M_IDLE);
      if (new_grant) begin
        checks++;
        if ((own_d && qd.size() == 0) || (!own_d && qi.size() == 0)) begin
          errors++;
          $display("FAIL grant_without_request: owner_d=%0d", own_d);
          cur = '{addr: 32'h0, we: 1'b0, wdata: 32'h0, exp: 32'h0};
        end else begin
          cur = own_d ? qd[0] : qi[0];
          chk(own_d ? "grant_d_address" : "grant_i_address", bus.m_address, cur.addr);
          if (cur.we) chk("grant_store_data", bus.m_data_write, cur.wdata);
        end
      end
      if (ms == M_GRANT) chk("m_we_grant", bus.m_write_enable, cur.we);
      else               chk("m_we_idle", bus.m_write_enable, 0);
      chk("i_data_valid", bus.i_data_valid, ms == M_RESP && !own_d);
      chk("d_data_valid", bus.d_data_valid, ms == M_RESP && own_d);
      chk("arb_err", arb_err, ms == M_RESP && m_tmo);
      if (ms == M_RESP) begin
        rexp = m_tmo ? 32'hDEADBEEF : cur.exp;
        if (own_d) begin exp_drd = rexp; if (qd.size() > 0) void'(qd.pop_front()); end
        else       begin exp_ird = rexp; if (qi.size() > 0) void'(qi.pop_front()); end
      end
      chk("i_data_read", bus.i_data_read, exp_ird);
      chk("d_data_read", bus.d_data_read, exp_drd);
      p_i = bus.i_req; p_d = bus.d_req; p_mv = bus.m_data_valid;
    end
  end

  // Auto memory: random 0..3 cycle latency, data is a fixed function of the address
  bit in_access = 1'b0;
  int lat;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!reset_n) in_access = 1'b0;
      if (mem_auto) begin
        bus.m_data_valid = 1'b0;
        if (reset_n && bus.m_req) begin
          if (!in_access) begin in_access = 1'b1; lat = $urandom_range(0, 3); end
          if (lat == 0) begin
            bus.m_data_valid = 1'b1;
            bus.m_data_read  = mem_f(bus.m_address);
            in_access = 1'b0;
          end else lat--;
        end
      end
    end
  end

  task automatic access(input bit port_d, input logic [31:0] a, input bit we,
                        input logic [31:0] wd, input logic [31:0] rd, input bit keep);
    txn_t t;
    int   n;
    t.addr = a; t.we = we; t.wdata = wd; t.exp = we ? 32'h0 : rd;
    if (port_d) begin
      if (!bus.d_req) begin @(posedge clk); #1; end
      bus.d_req = 1'b1; bus.d_address = a; bus.d_write_enable = we; bus.d_data_write = wd;
      qd.push_back(t);
    end else begin
      if (!bus.i_req) begin @(posedge clk); #1; end
      bus.i_req = 1'b1; bus.i_address = a;
      qi.push_back(t);
    end
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(port_d ? bus.d_data_valid : bus.i_data_valid) && n < 300);
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_valid_timeout: no valid after %0d cycles, required one", port_d ? "d" : "i", n);
    end
    @(posedge clk); #1;
    if (!keep) begin
      if (port_d) bus.d_req = 1'b0;
      else        bus.i_req = 1'b0;
    end
  endtask

  task automatic wait_mreq();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.m_req && n < 100);
    checks++;
    if (!bus.m_req) begin
      errors++;
      $display("FAIL m_req_wait: got 0 expected 1 within 100 cycles");
    end
  endtask

  task automatic mem_reply(input int dly, input logic [31:0] data);
    wait_mreq();
    repeat (dly) begin @(posedge clk); #1; end
    bus.m_data_valid = 1'b1; bus.m_data_read = data;
    @(posedge clk); #1;
    bus.m_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.i_req = 1'b0; bus.i_address = '0;
    bus.d_req = 1'b0; bus.d_address = '0; bus.d_data_write = '0; bus.d_write_enable = 1'b0;
    bus.m_data_read = '0; bus.m_data_valid = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(2);

    fork
      access(1'b0, 32'h40, 1'b0, 32'h0, 32'h12345678, 1'b0);
      mem_reply(3, 32'h12345678);
    join
    idle(2);

    fork
      access(1'b1, 32'h100, 1'b1, 32'hCAFEF00D, 32'h0, 1'b0);
      mem_reply(0, 32'h77777777);
    join
    idle(2);

    // Both ports held from reset: grants must go D, I, D, I
    reset_n = 1'b0;
    mem_auto = 1'b1;
    fork
      begin
        access(1'b1, 32'h300, 1'b0, 32'h0, mem_f(32'h300), 1'b1);
        access(1'b1, 32'h300, 1'b0, 32'h0, mem_f(32'h300), 1'b0);
      end
      begin
        access(1'b0, 32'h200, 1'b0, 32'h0, mem_f(32'h200), 1'b1);
        access(1'b0, 32'h200, 1'b0, 32'h0, mem_f(32'h200), 1'b0);
      end
      begin idle(2); reset_n = 1'b1; end
    join
    idle(2);

    // Reset two cycles into a data grant, late completion afterwards
    mem_auto = 1'b0;
    bus.m_data_valid = 1'b0;
    bus.d_req = 1'b1; bus.d_address = 32'h180; bus.d_write_enable = 1'b0;
    qd.push_back('{addr: 32'h180, we: 1'b0, wdata: 32'h0, exp: 32'h0});
    wait_mreq();
    idle(1);
    reset_n = 1'b0; bus.d_req = 1'b0;
    idle(1);
    reset_n = 1'b1; qd.delete();
    idle(1);
    bus.m_data_valid = 1'b1; bus.m_data_read = 32'h99999999;
    idle(1);
    bus.m_data_valid = 1'b0;
    idle(3);

    // Fetch request held past its valid starts a second access
    mem_auto = 1'b1;
    access(1'b0, 32'h44, 1'b0, 32'h0, mem_f(32'h44), 1'b1);
    access(1'b0, 32'h44, 1'b0, 32'h0, mem_f(32'h44), 1'b0);
    idle(2);

    // Silent memory: watchdog fires, or the grant simply waits
    mem_auto = 1'b0;
    bus.m_data_valid = 1'b0;
`ifdef DLX_MEM_ARB_TIMEOUT_EN
    access(1'b0, 32'h80, 1'b0, 32'h0, 32'h0, 1'b0);
`else
    fork
      access(1'b0, 32'h80, 1'b0, 32'h0, 32'h55AA55AA, 1'b0);
      mem_reply(20, 32'h55AA55AA);
    join
`endif
    idle(2);

    mem_auto = 1'b1;
    fork
      for (int k = 0; k < 40; k++) begin
        idle($urandom_range(0, 3));
        access(1'b0, {$urandom_range(0, 255), 2'b00}, 1'b0, 32'h0, 32'h0, 1'b0);
      end
      for (int k = 0; k < 40; k++) begin
        logic [31:0] a;
        logic        w;
        a = {$urandom_range(0, 255), 2'b00};
        w = 1'($urandom_range(0, 1));
        idle($urandom_range(0, 3));
        access(1'b1, a, w, $urandom, mem_f(a), 1'b0);
      end
    join
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Random fetches use the auto memory, so their expected data is patched here at issue time
  always @(negedge clk) begin
    foreach (qi[k]) if (qi[k].exp == 32'h0 && mem_auto && qi[k].addr != 32'h80) qi[k].exp = mem_f(qi[k].addr);
  end

endmodule
